// File: rtl/l1_i_controller_pkg.sv
// rtl/l1_i_controller_pkg.sv - shared types and constants for the L1 instruction cache controller
package L1_I_pkg;

    typedef enum logic [1:0] {IDLE, COMPARE, MISS} l1i_state_t;

    localparam int OFFSET_W = 6;
    localparam int LINE_W   = 512;
    localparam int WAYS     = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/l1_i_controller_tag_array.sv
// rtl/l1_i_controller_tag_array.sv - two-way tag/valid/LRU store with hit and victim lookup
module L1_I_tag_array
    import L1_I_pkg::*;
#(
    parameter int TNUM = 21,
    parameter int INUM = 26 - TNUM
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [INUM-1:0] index,
    input  logic [TNUM-1:0] tag,
    input  logic            tag_we,
    input  logic            way,
    input  logic            lru_we,
    input  logic            lru_val,
    output logic            hit0,
    output logic            hit1,
    output logic            victim
);

    localparam int SETS = 2 ** INUM;

    logic [TNUM-1:0] tag_q   [WAYS][SETS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [SETS-1:0] lru_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[w][s] <= '0;
                end
            end
            lru_q <= '0;
        end else begin
            if (tag_we) begin
                tag_q[way][index]   <= tag;
                valid_q[index][way] <= 1'b1;
            end
            if (lru_we) begin
                lru_q[index] <= lru_val;
            end
        end
    end

    assign hit0 = valid_q[index][0] && (tag_q[0][index] == tag);
    assign hit1 = valid_q[index][1] && (tag_q[1][index] == tag);

    // Fill empty ways first so the LRU bit only arbitrates a full set
    assign victim = !valid_q[index][0] ? 1'b0 :
                    !valid_q[index][1] ? 1'b1 : lru_q[index];

endmodule

// File: rtl/l1_i_controller.sv
// rtl/l1_i_controller.sv - fetch/compare/refill FSM and performance counters for the two-way L1 I-cache
module l1_i_controller
    import L1_I_pkg::*;
#(
    parameter int TNUM = 21,
    parameter int INUM = 26 - TNUM
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                read_C_L1,
    input  logic [31:0]         address_C_L1,
    output logic                ready_L1_C,
    output logic                read_L1_L2,
    output logic [25:0]         address_L1_L2,
    input  logic                ready_L2_L1,
    output logic [INUM-1:0]     index_C_L1,
    output logic [OFFSET_W-1:0] offset,
    output logic                refill,
    output logic                way,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    l1i_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        victim_q, victim_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    logic hit0, hit1, victim;
    logic tag_we, lru_we, lru_val;

    L1_I_tag_array #(
        .TNUM (TNUM),
        .INUM (INUM)
    ) u_tag_array (
        .clk     (clk),
        .nrst    (nrst),
        .index   (addr_q[OFFSET_W +: INUM]),
        .tag     (addr_q[31 -: TNUM]),
        .tag_we  (tag_we),
        .way     (way),
        .lru_we  (lru_we),
        .lru_val (lru_val),
        .hit0    (hit0),
        .hit1    (hit1),
        .victim  (victim)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            victim_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            victim_q     <= victim_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        victim_d     = victim_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        ready_L1_C   = 1'b0;
        read_L1_L2   = 1'b0;
        refill       = 1'b0;
        way          = 1'b0;
        tag_we       = 1'b0;
        lru_we       = 1'b0;
        lru_val      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read_C_L1) begin
                    addr_d  = address_C_L1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit0 || hit1) begin
                    // A double hit cannot arise from refills; way0 takes it if it does
                    way         = !hit0;
                    ready_L1_C  = 1'b1;
                    lru_we      = 1'b1;
                    lru_val     = hit0;
                    hit_count_d = sat_inc(hit_count_q);
                    state_d     = IDLE;
                end else begin
                    victim_d     = victim;
                    miss_count_d = sat_inc(miss_count_q);
                    state_d      = MISS;
                end
            end
            MISS: begin
                read_L1_L2 = 1'b1;
                if (ready_L2_L1) begin
                    refill  = 1'b1;
                    way     = victim_q;
                    tag_we  = 1'b1;
                    lru_we  = 1'b1;
                    lru_val = !victim_q;
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign address_L1_L2 = addr_q[31:OFFSET_W];
    assign index_C_L1    = addr_q[OFFSET_W +: INUM];
    assign offset        = addr_q[OFFSET_W-1:0];
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_l1_i_controller.sv
// tb/tb_l1_i_controller.sv - directed self-checking bench for l1_i_controller
module tb_l1_i_controller;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        read_C_L1 = 1'b0;
    logic [31:0] address_C_L1 = '0;
    logic        ready_L1_C;
    logic        read_L1_L2;
    logic [25:0] address_L1_L2;
    logic        ready_L2_L1 = 1'b0;
    logic [4:0]  index_C_L1;
    logic [5:0]  offset;
    logic        refill;
    logic        way;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    l1_i_controller #(.TNUM(21)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .read_C_L1     (read_C_L1),
        .address_C_L1  (address_C_L1),
        .ready_L1_C    (ready_L1_C),
        .read_L1_L2    (read_L1_L2),
        .address_L1_L2 (address_L1_L2),
        .ready_L2_L1   (ready_L2_L1),
        .index_C_L1    (index_C_L1),
        .offset        (offset),
        .refill        (refill),
        .way           (way),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left in IDLE, 1ns after a rising edge
    task automatic fetch(input string nm, input logic [31:0] a, input bit exp_miss,
                         input bit exp_way, input int lat, input bit l2_in_cmp,
                         input logic [31:0] exp_hits, input logic [31:0] exp_misses);
        logic [25:0] exp_line;
        logic [4:0]  exp_idx;
        logic [5:0]  exp_off;
        exp_line = a[31:6];
        exp_idx  = a[10:6];
        exp_off  = a[5:0];
        read_C_L1 = 1'b1;
        address_C_L1 = a;
        #1;
        n_checks++;
        if (ready_L1_C !== 1'b0) begin n_fail++; $display("FAIL %s_idle_ready: got %0b exp 0", nm, ready_L1_C); end
        tick();
        read_C_L1 = 1'b0;
        address_C_L1 = 32'hDEAD_BEEF;
        ready_L2_L1 = l2_in_cmp;
        #1;
        n_checks++;
        if (index_C_L1 !== exp_idx || offset !== exp_off) begin
            n_fail++; $display("FAIL %s_latch: got idx %0h off %0h exp idx %0h off %0h", nm, index_C_L1, offset, exp_idx, exp_off);
        end
        n_checks++;
        if (refill !== 1'b0 || read_L1_L2 !== 1'b0) begin
            n_fail++; $display("FAIL %s_cmp_quiet: got refill %0b read_L2 %0b exp 0 0", nm, refill, read_L1_L2);
        end
        n_checks++;
        if (ready_L1_C !== !exp_miss) begin n_fail++; $display("FAIL %s_cmp_ready: got %0b exp %0b", nm, ready_L1_C, !exp_miss); end
        if (!exp_miss) begin
            n_checks++;
            if (way !== exp_way) begin n_fail++; $display("FAIL %s_hit_way: got %0b exp %0b", nm, way, exp_way); end
        end
        tick();
        ready_L2_L1 = 1'b0;
        if (exp_miss) begin
            for (int i = 0; i < lat; i++) begin
                #1;
                n_checks++;
                if (read_L1_L2 !== 1'b1 || refill !== 1'b0) begin
                    n_fail++; $display("FAIL %s_wait%0d: got read_L2 %0b refill %0b exp 1 0", nm, i, read_L1_L2, refill);
                end
                tick();
            end
            ready_L2_L1 = 1'b1;
            #1;
            n_checks++;
            if (read_L1_L2 !== 1'b1 || address_L1_L2 !== exp_line) begin
                n_fail++; $display("FAIL %s_l2_req: got read %0b addr %0h exp 1 %0h", nm, read_L1_L2, address_L1_L2, exp_line);
            end
            n_checks++;
            if (refill !== 1'b1 || way !== exp_way || ready_L1_C !== 1'b0) begin
                n_fail++; $display("FAIL %s_refill: got refill %0b way %0b ready %0b exp 1 %0b 0", nm, refill, way, ready_L1_C, exp_way);
            end
            tick();
            ready_L2_L1 = 1'b0;
            #1;
            n_checks++;
            if (ready_L1_C !== 1'b1 || way !== exp_way || refill !== 1'b0 || read_L1_L2 !== 1'b0) begin
                n_fail++; $display("FAIL %s_recmp: got ready %0b way %0b refill %0b read_L2 %0b exp 1 %0b 0 0", nm, ready_L1_C, way, refill, read_L1_L2, exp_way);
            end
            tick();
        end
        #1;
        n_checks++;
        if (ready_L1_C !== 1'b0 || read_L1_L2 !== 1'b0) begin
            n_fail++; $display("FAIL %s_back_idle: got ready %0b read_L2 %0b exp 0 0", nm, ready_L1_C, read_L1_L2);
        end
        n_checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            n_fail++; $display("FAIL %s_counters: got hits %0d misses %0d exp %0d %0d", nm, hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ready_L1_C, read_L1_L2, refill, way} !== 4'b0 || address_L1_L2 !== 26'h0 ||
            index_C_L1 !== 5'h0 || offset !== 6'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got ready %0b read %0b refill %0b way %0b addr %0h idx %0h off %0h hits %0d misses %0d exp all 0",
                               ready_L1_C, read_L1_L2, refill, way, address_L1_L2, index_C_L1, offset, hit_count, miss_count);
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_miss_fill();
        fetch("miss_0040", 32'h0000_0040, 1'b1, 1'b0, 4, 1'b0, 32'd1, 32'd1);
    endtask

    task automatic test_hit();
        fetch("hit_0044", 32'h0000_0044, 1'b0, 1'b0, 0, 1'b0, 32'd2, 32'd1);
    endtask

    task automatic test_lru();
        fetch("miss_0840", 32'h0000_0840, 1'b1, 1'b1, 2, 1'b0, 32'd3, 32'd2);
        fetch("miss_1040", 32'h0000_1040, 1'b1, 1'b0, 1, 1'b0, 32'd4, 32'd3);
        fetch("evict_0040", 32'h0000_0040, 1'b1, 1'b1, 0, 1'b0, 32'd5, 32'd4);
    endtask

    task automatic test_l2_ignored();
        ready_L2_L1 = 1'b1;
        #1;
        n_checks++;
        if (refill !== 1'b0 || read_L1_L2 !== 1'b0) begin
            n_fail++; $display("FAIL l2_idle: got refill %0b read_L2 %0b exp 0 0", refill, read_L1_L2);
        end
        tick();
        ready_L2_L1 = 1'b0;
        #1;
        n_checks++;
        if (ready_L1_C !== 1'b0 || read_L1_L2 !== 1'b0 || refill !== 1'b0) begin
            n_fail++; $display("FAIL l2_idle_after: got ready %0b read_L2 %0b refill %0b exp 0 0 0", ready_L1_C, read_L1_L2, refill);
        end
        fetch("l2_in_cmp", 32'h0000_0044, 1'b0, 1'b1, 0, 1'b1, 32'd6, 32'd4);
    endtask

    task automatic test_back_to_back();
        fetch("b2b_007c", 32'h0000_007C, 1'b0, 1'b1, 0, 1'b0, 32'd7, 32'd4);
        fetch("b2b_1044", 32'h0000_1044, 1'b0, 1'b0, 0, 1'b0, 32'd8, 32'd4);
    endtask

    task automatic test_reset_mid_miss();
        read_C_L1 = 1'b1;
        address_C_L1 = 32'h0000_2040;
        tick();
        read_C_L1 = 1'b0;
        tick();
        tick();
        #1;
        n_checks++;
        if (read_L1_L2 !== 1'b1 || address_L1_L2 !== 26'h81) begin
            n_fail++; $display("FAIL mid_miss_req: got read %0b addr %0h exp 1 81", read_L1_L2, address_L1_L2);
        end
        #2;
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({ready_L1_C, read_L1_L2, refill, way} !== 4'b0 || address_L1_L2 !== 26'h0 ||
            index_C_L1 !== 5'h0 || offset !== 6'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got ready %0b read %0b refill %0b way %0b addr %0h idx %0h off %0h hits %0d misses %0d exp all 0",
                               ready_L1_C, read_L1_L2, refill, way, address_L1_L2, index_C_L1, offset, hit_count, miss_count);
        end
        tick();
        nrst = 1'b1;
        ready_L2_L1 = 1'b1;
        #1;
        n_checks++;
        if (refill !== 1'b0 || read_L1_L2 !== 1'b0) begin
            n_fail++; $display("FAIL late_l2: got refill %0b read_L2 %0b exp 0 0", refill, read_L1_L2);
        end
        tick();
        ready_L2_L1 = 1'b0;
        #1;
        n_checks++;
        if (ready_L1_C !== 1'b0 || read_L1_L2 !== 1'b0) begin
            n_fail++; $display("FAIL late_l2_after: got ready %0b read_L2 %0b exp 0 0", ready_L1_C, read_L1_L2);
        end
        fetch("refetch_0040", 32'h0000_0040, 1'b1, 1'b0, 0, 1'b0, 32'd1, 32'd1);
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_lru();
        test_l2_ignored();
        test_back_to_back();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
